// File: rtl/sp_bram_rr_arbiter.sv
// Round-robin arbiter that shares one single-port, byte-write-enable BRAM among
// NUM_REQ requesters, with an optional zero-fill of the whole array after reset.
module sp_bram_rr_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_wr,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]    req_be,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_adr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_wdat,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_rdat,
    output logic                                 init_busy,
    output logic                                 ram_re,
    output logic [DATA_WIDTH/8-1:0]              ram_we,
    output logic [ADDR_WIDTH-1:0]                ram_adr,
    output logic [DATA_WIDTH-1:0]                ram_wdat,
    input  logic [DATA_WIDTH-1:0]                ram_rdat
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_ADR = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [PTR_W-1:0]    LAST_REQ = PTR_W'(NUM_REQ - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH:0]    clr_reg, clr_next;
    logic [PTR_W-1:0]       ptr_reg, ptr_next;
    logic [NUM_REQ-1:0]     rsp_valid_reg, rsp_valid_next;

    logic [BE_W-1:0]        be_arr   [NUM_REQ];
    logic [ADDR_WIDTH-1:0]  adr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdat_arr [NUM_REQ];

    logic                   gnt_found;
    logic [PTR_W-1:0]       gnt_idx;
    logic [PTR_W-1:0]       cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign be_arr[gi]   = req_be[gi*BE_W +: BE_W];
            assign adr_arr[gi]  = req_adr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdat_arr[gi] = req_wdat[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr_reg) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        clr_next       = clr_reg;
        ptr_next       = ptr_reg;
        rsp_valid_next = '0;
        req_ready      = '0;
        ram_re         = 1'b0;
        ram_we         = '0;
        ram_adr        = '0;
        ram_wdat       = '0;
        if (!rst) begin
            case (state_reg)
                ST_INIT: begin
                    ram_we   = '1;
                    ram_adr  = clr_reg[ADDR_WIDTH-1:0];
                    clr_next = clr_reg + (ADDR_WIDTH + 1)'(1);
                    if (clr_reg == LAST_ADR) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (gnt_found) begin
                        req_ready[gnt_idx] = 1'b1;
                        ptr_next = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + PTR_W'(1);
                        ram_adr  = adr_arr[gnt_idx];
                        if (req_wr[gnt_idx]) begin
                            ram_we   = be_arr[gnt_idx];
                            ram_wdat = wdat_arr[gnt_idx];
                        end else begin
                            ram_re                  = 1'b1;
                            rsp_valid_next[gnt_idx] = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            clr_reg       <= '0;
            ptr_reg       <= '0;
            rsp_valid_reg <= '0;
        end else begin
            state_reg     <= state_next;
            clr_reg       <= clr_next;
            ptr_reg       <= ptr_next;
            rsp_valid_reg <= rsp_valid_next;
        end
    end

    // RAM output is already registered; it only needs qualifying by the issuing read.
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdat  = (|rsp_valid_reg) ? ram_rdat : '0;
    assign init_busy = rst ? (INIT_ON_RESET != 0) : (state_reg == ST_INIT);

endmodule

// File: tb/tb_sp_bram_rr_arbiter.sv
// Directed bench for sp_bram_rr_arbiter with a behavioural byte-enable RAM and
// a read-response scoreboard fed from a shadow copy of the expected RAM contents.
module tb_sp_bram_rr_arbiter;
    localparam int NR    = 4;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int BE    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_wr, req_ready, rsp_valid;
    logic [NR*BE-1:0]  req_be;
    logic [NR*AW-1:0]  req_adr;
    logic [NR*DW-1:0]  req_wdat;
    logic [DW-1:0]     rsp_rdat, ram_wdat, ram_rdat;
    logic              init_busy, ram_re;
    logic [BE-1:0]     ram_we;
    logic [AW-1:0]     ram_adr;

    always #5 clk = ~clk;

    sp_bram_rr_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_be(req_be),
        .req_adr(req_adr), .req_wdat(req_wdat), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdat(rsp_rdat), .init_busy(init_busy),
        .ram_re(ram_re), .ram_we(ram_we), .ram_adr(ram_adr),
        .ram_wdat(ram_wdat), .ram_rdat(ram_rdat)
    );

    // Behavioural single-port RAM: registered read, read wins over write.
    logic          preload;
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '1;
        end else if (ram_re) begin
            ram_rdat <= mem[ram_adr];
        end else begin
            for (int b = 0; b < BE; b++)
                if (ram_we[b]) mem[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];
        end
    end

    typedef struct {
        int          id;
        logic [DW-1:0] dat;
    } exp_t;
    exp_t          sbq [$];
    logic [DW-1:0] exp_mem [DEPTH];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp();
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rsp_valid", rsp_valid, 64'(1 << e.id));
            chk("rsp_rdat", rsp_rdat, e.dat);
            $display("rsp  req%0d data %h (expected %h)", e.id, rsp_rdat, e.dat);
        end else begin
            chk("rsp_idle", rsp_valid, 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_rsp();
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic [BE-1:0] be,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_wr[i]             = w;
        req_be[i*BE +: BE]    = be;
        req_adr[i*AW +: AW]   = a;
        req_wdat[i*DW +: DW]  = d;
    endtask

    task automatic accept();
        logic [AW-1:0] a;
        logic [BE-1:0] be;
        logic [DW-1:0] d;
        for (int g = 0; g < NR; g++) begin
            if (req_valid[g] && req_ready[g]) begin
                a  = req_adr[g*AW +: AW];
                be = req_be[g*BE +: BE];
                d  = req_wdat[g*DW +: DW];
                chk("ram_adr", ram_adr, a);
                if (req_wr[g]) begin
                    chk("ram_we_wr", ram_we, be);
                    chk("ram_wdat", ram_wdat, d);
                    chk("ram_re_wr", ram_re, 0);
                    for (int b = 0; b < BE; b++)
                        if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
                    $display("wr   req%0d adr %0d be %b data %h", g, a, be, d);
                end else begin
                    chk("ram_re_rd", ram_re, 1);
                    chk("ram_we_rd", ram_we, 0);
                    sbq.push_back('{g, exp_mem[a]});
                    $display("rd   req%0d adr %0d", g, a);
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic [NR-1:0] exp_ready);
        #1;
        chk(tag, req_ready, exp_ready);
        if (exp_ready == '0) begin
            chk("idle_we", ram_we, 0);
            chk("idle_re", ram_re, 0);
            chk("idle_adr", ram_adr, 0);
        end
        accept();
        tick();
    endtask

    task automatic fill_check();
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("fill_busy", init_busy, 1);
            chk("fill_ready", req_ready, 0);
            chk("fill_we", ram_we, {BE{1'b1}});
            chk("fill_adr", ram_adr, i);
            chk("fill_wdat", ram_wdat, 0);
            chk("fill_re", ram_re, 0);
            $display("fill adr %0d we %b", ram_adr, ram_we);
            tick();
        end
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    endtask

    initial begin
        rst = 1'b1; preload = 1'b1;
        req_valid = '0; req_wr = '0; req_be = '0; req_adr = '0; req_wdat = '0;
        @(posedge clk);
        #1;
        preload = 1'b0;
        repeat (2) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_re", ram_re, 0);
            chk("rst_we", ram_we, 0);
            chk("rst_adr", ram_adr, 0);
            chk("rst_wdat", ram_wdat, 0);
            chk("rst_busy", init_busy, 1);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdat", rsp_rdat, 0);
            @(posedge clk);
            #1;
        end

        // Requesters already valid during the fill; none may be granted until it ends.
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, '0, AW'(i), '0);
        rst = 1'b0;
        fill_check();
        chk("busy_after_fill", init_busy, 0);

        for (int k = 0; k < 2*NR; k++) step("rr_grant", NR'(1 << (k % NR)));

        req_valid = '0;
        for (int a = 0; a < DEPTH; a++) begin
            set_req(2, 1'b1, 1'b0, '0, AW'(a), '0);
            step("zero_rd", 4'b0100);
        end

        req_valid = '0;
        set_req(3, 1'b1, 1'b0, '0, 4'd7, '0);
        step("ptr_only3", 4'b1000);
        set_req(0, 1'b1, 1'b0, '0, 4'd8, '0);
        step("ptr_0_first", 4'b0001);
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        step("ptr_3_second", 4'b1000);

        req_valid = '0;
        set_req(1, 1'b1, 1'b1, 4'hF, 4'd5, 32'hDEADBEEF);
        set_req(2, 1'b1, 1'b1, 4'h1, 4'd5, 32'h000000AA);
        step("merge_w1", 4'b0010);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        step("merge_w2", 4'b0100);
        req_valid = '0;
        set_req(0, 1'b1, 1'b0, '0, 4'd5, '0);
        step("merge_rd", 4'b0001);
        req_valid = '0;
        step("idle", 4'b0000);

        set_req(3, 1'b1, 1'b1, 4'h0, 4'd5, 32'hFFFFFFFF);
        step("noop_w", 4'b1000);
        req_valid = '0;
        set_req(0, 1'b1, 1'b0, '0, 4'd5, '0);
        step("noop_rd", 4'b0001);

        req_valid = '0;
        set_req(1, 1'b1, 1'b0, '0, 4'd5, '0);
        step("pre_rst_rd", 4'b0010);
        rst = 1'b1;
        req_valid = '0;
        set_req(0, 1'b1, 1'b0, '0, 4'd5, '0);
        #1;
        chk("rst_mid_ready", req_ready, 0);
        chk("rst_mid_we", ram_we, 0);
        chk("rst_mid_re", ram_re, 0);
        chk("rst_mid_busy", init_busy, 1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, '0, 4'd5, '0);
        fill_check();
        step("ptr_restart", 4'b0001);
        req_valid = '0;
        step("tail", 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
